lut_multiplier: RTL and testbench
=================================

Name: lut_multiplier

Overview:
- Unsigned 16x16 -> 32-bit multiplier for the MiniALU datapath.
- Built from 4x4-bit lookup-table partial products and evaluated iteratively: one 4-bit nibble of B per clock, accumulated into a 32-bit result.
- Start/done handshake; result register holds until the next completion.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of 4; oOUT is 2*WIDTH bits.
- NIBBLES, WIDTH/4, derived iteration count; not to be overridden.

Ports:
- Clock  input  1  rising-edge system clock
- Reset  input  1  asynchronous, active-low reset
- iStart  input  1  request a multiply; sampled on rising Clock
- wA  input  WIDTH  multiplicand, unsigned
- wB  input  WIDTH  multiplier, unsigned
- oOUT  output  2*WIDTH  product register
- oBusy  output  1  high while an operation is in progress
- oDone  output  1  one-cycle pulse when oOUT is updated

Behaviour:
- Reset low, asynchronous: oOUT=0, oDone=0, oBusy=0, internal accumulator, operand latches and nibble counter all 0. Release is synchronous to the next Clock edge.
- States: IDLE and RUN, encoded by oBusy.
- IDLE, rising edge with iStart=1:
  - latch wA and wB into internal registers;
  - clear the accumulator; set counter=0; oBusy<=1.
  - wA/wB changes after this edge do not affect the result.
- RUN, each edge k=0..NIBBLES-1:
  - acc <= acc + ((A_lat * B_lat[4k+3:4k]) << 4k);
  - A_lat * nibble = sum of the NIBBLES LUT products (A_lat[4j+3:4j] * nibble) << 4j;
  - counter increments.
- Final RUN edge (k=NIBBLES-1):
  - oOUT <= completed sum; oDone<=1; oBusy<=0.
- Timing:
  - latency: oOUT valid and oDone high in the cycle after the NIBBLES-th edge following the start edge (4 edges for WIDTH=16);
  - oDone is high for exactly one cycle;
  - throughput is one product per NIBBLES+1 cycles.
- iStart while oBusy=1 is ignored; the operation in progress is unaffected.
- iStart in the oDone cycle (oBusy=0) is accepted, so operations can run back-to-back.
- oOUT holds its last value between completions. It never shows partial sums.
- Arithmetic:
  - fully unsigned; accumulator is 2*WIDTH bits;
  - no overflow is possible: max 0xFFFF*0xFFFF = 0xFFFE0001.
- Reset asserted mid-operation: the operation is aborted, all outputs return to reset values, and no oDone is produced.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package mult_pkg:
  - constants WIDTH=16, NIB_W=4, NIBBLES;
  - state typedef {IDLE, RUN}.
- One sub-module, lut4x4_mul: purely combinational 256-entry lookup table, 4-bit x 4-bit -> 8-bit unsigned product.
  - Written as an explicit case table, not the * operator.
  - Instantiated NIBBLES times, once per A nibble, all sharing the current B nibble.
- Top level contains the operand latches, counter, accumulator, shift-and-add tree and handshake.

Test Plan:
- Reset low for 3 cycles, then release -> oOUT=0x00000000, oBusy=0, oDone=0. A start on the first edge after release is accepted.
- wA=5, wB=5, iStart pulse -> oBusy high for 4 cycles, then oDone pulses once with oOUT=0x00000019 (25); oOUT stays 25 afterwards.
- wA=0xFFFF, wB=0xFFFF -> oOUT=0xFFFE0001. Then wA=0x1234, wB=0x5678 started in the oDone cycle -> oOUT=0x06260060.
- wA=0x0000, wB=0xBEEF -> oOUT=0. wA=0x0001, wB=0x8000 -> oOUT=0x00008000.
- Start 0x0003*0x0007; change wA/wB and re-assert iStart while oBusy=1 -> a single oDone with oOUT=0x00000015; the second request is ignored.
- Start 0x00FF*0x0100; drive Reset low two cycles after start -> outputs clear immediately and no oDone pulse occurs. Re-run after release -> oOUT=0x0000FF00.

Source files
------------

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and state type for the LUT multiplier
// Purpose: operand width, nibble size, derived iteration count and the
//          IDLE/RUN state encoding used by lut_multiplier.
// Ports:   none (package).
package mult_pkg;

    localparam int WIDTH   = 16;
    localparam int NIB_W   = 4;
    localparam int NIBBLES = WIDTH / NIB_W;

    // RUN is encoded as 1 so the state bit doubles as the busy flag.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/lut4x4_mul.sv
// rtl/lut4x4_mul.sv - 4x4 -> 8-bit unsigned product lookup table
// Purpose: purely combinational 256-entry product table.
// Ports:   a_i  4-bit multiplicand nibble
//          b_i  4-bit multiplier nibble
//          p_o  8-bit unsigned product a_i * b_i
module lut4x4_mul (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);

    // One 128-bit row per value of a_i; byte n of the row holds a_i * n,
    // with n = 15 in the most significant byte.
    logic [127:0] row;

    always_comb begin
        row = '0;
        case (a_i)
            4'h0: row = 128'h00000000000000000000000000000000;
            4'h1: row = 128'h0F0E0D0C0B0A09080706050403020100;
            4'h2: row = 128'h1E1C1A18161412100E0C0A0806040200;
            4'h3: row = 128'h2D2A2724211E1B1815120F0C09060300;
            4'h4: row = 128'h3C3834302C2824201C1814100C080400;
            4'h5: row = 128'h4B46413C37322D28231E19140F0A0500;
            4'h6: row = 128'h5A544E48423C36302A241E18120C0600;
            4'h7: row = 128'h69625B544D463F38312A231C150E0700;
            4'h8: row = 128'h78706860585048403830282018100800;
            4'h9: row = 128'h877E756C635A51483F362D241B120900;
            4'hA: row = 128'h968C82786E645A50463C32281E140A00;
            4'hB: row = 128'hA59A8F84796E63584D42372C21160B00;
            4'hC: row = 128'hB4A89C9084786C6054483C3024180C00;
            4'hD: row = 128'hC3B6A99C8F8275685B4E4134271A0D00;
            4'hE: row = 128'hD2C4B6A89A8C7E70625446382A1C0E00;
            4'hF: row = 128'hE1D2C3B4A5968778695A4B3C2D1E0F00;
            default: row = '0;
        endcase
        p_o = row[{b_i, 3'b000} +: 8];
    end

endmodule

// File: rtl/lut_multiplier.sv
// rtl/lut_multiplier.sv - iterative 16x16 -> 32-bit unsigned LUT multiplier
// Purpose: multiplies wA by wB one B nibble per clock using 4x4 LUT partial
//          products; start/done handshake, result register holds between ops.
// Ports:   Clock   rising-edge clock
//          Reset   asynchronous active-low reset
//          iStart  request a multiply (ignored while busy)
//          wA, wB  WIDTH-bit unsigned operands, latched on the start edge
//          oOUT    2*WIDTH-bit product register
//          oBusy   high while an operation is in progress
//          oDone   one-cycle pulse when oOUT is updated
module lut_multiplier
    import mult_pkg::state_t, mult_pkg::IDLE, mult_pkg::RUN, mult_pkg::NIB_W;
#(
    parameter int WIDTH = mult_pkg::WIDTH
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iStart,
    input  logic [WIDTH-1:0]   wA,
    input  logic [WIDTH-1:0]   wB,
    output logic [2*WIDTH-1:0] oOUT,
    output logic               oBusy,
    output logic               oDone
);

    localparam int NIBBLES = WIDTH / NIB_W;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int PP_W    = WIDTH + NIB_W;
    localparam int OUT_W   = 2 * WIDTH;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               done_q, done_d;

    logic [NIB_W-1:0]   b_nib;
    logic [2*NIB_W-1:0] lut_p [NIBBLES];
    logic [PP_W-1:0]    pp;
    logic [OUT_W-1:0]   acc_sum;
    logic               last_nib;

    // Current B nibble selected by the iteration counter.
    assign b_nib    = NIB_W'(b_q >> (cnt_q * NIB_W));
    assign last_nib = (cnt_q == CNT_W'(NIBBLES - 1));

    for (genvar j = 0; j < NIBBLES; j++) begin : g_lut
        lut4x4_mul u_lut (
            .a_i (a_q[j*NIB_W +: NIB_W]),
            .b_i (b_nib),
            .p_o (lut_p[j])
        );
    end

    // A * nibble via shifted LUT products, then aligned to the nibble position.
    always_comb begin
        pp = '0;
        for (int j = 0; j < NIBBLES; j++) begin
            pp = pp + (PP_W'(lut_p[j]) << (j * NIB_W));
        end
        acc_sum = acc_q + (OUT_W'(pp) << (cnt_q * NIB_W));
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (iStart)   state_d = RUN;
            RUN:     if (last_nib) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        out_d  = out_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (iStart) begin
                    a_d   = wA;
                    b_d   = wB;
                    cnt_d = '0;
                    acc_d = '0;
                end
            end
            RUN: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 1'b1;
                // Only the completed sum reaches oOUT, never a partial one.
                if (last_nib) begin
                    out_d  = acc_sum;
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            a_q    <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            acc_q  <= '0;
            out_q  <= '0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            out_q  <= out_d;
            done_q <= done_d;
        end
    end

    assign oOUT  = out_q;
    assign oBusy = (state_q == RUN);
    assign oDone = done_q;

endmodule

// File: tb/tb_lut_multiplier.sv
// tb/tb_lut_multiplier.sv - self-checking bench for lut_multiplier
module tb_lut_multiplier;

    localparam int W       = 16;
    localparam int NIBBLES = W / 4;

    logic          Clock;
    logic          Reset;
    logic          iStart;
    logic [W-1:0]  wA;
    logic [W-1:0]  wB;
    logic [2*W-1:0] oOUT;
    logic          oBusy;
    logic          oDone;

    int checks = 0;
    int passes = 0;
    bit chk_en = 0;

    lut_multiplier dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .iStart (iStart),
        .wA     (wA),
        .wB     (wB),
        .oOUT   (oOUT),
        .oBusy  (oBusy),
        .oDone  (oDone)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference model: product by plain arithmetic, busy for NIBBLES edges
    // after the accepting edge, then a single done cycle.
    logic [2*W-1:0] m_out, m_pend;
    logic           m_busy, m_done;
    int             m_left;

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            m_out  <= '0;
            m_pend <= '0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (iStart) begin
                    m_busy <= 1'b1;
                    m_pend <= {16'h0, wA} * {16'h0, wB};
                    m_left <= NIBBLES;
                end
            end else if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_out  <= m_pend;
                m_left <= 0;
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    always @(negedge Clock) begin
        if (chk_en) begin
            check("model_busy", 32'(oBusy), 32'(m_busy));
            check("model_done", 32'(oDone), 32'(m_done));
            check("model_out",  oOUT,       m_out);
        end
    end

    task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
        wA     = a;
        wB     = b;
        iStart = 1'b1;
        @(posedge Clock);
        #2;
        iStart = 1'b0;
    endtask

    // Waits (bounded) for oDone at negedges; checks result and latency.
    task automatic wait_done(input logic [31:0] exp, input int exp_lat, input string name);
        int  n    = 0;
        bit  seen = 0;
        while (n < 20 && !seen) begin
            @(negedge Clock);
            n++;
            if (oDone) seen = 1;
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_out"},       oOUT,      exp);
        check({name, "_latency"},   32'(n),    32'(exp_lat));
    endtask

    initial begin
        int nd;
        Reset  = 1'b0;
        iStart = 1'b0;
        wA     = '0;
        wB     = '0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        Reset  = 1'b1;
        chk_en = 1;
        check("rst_out",  oOUT,         32'h0);
        check("rst_busy", 32'(oBusy),   32'd0);
        check("rst_done", 32'(oDone),   32'd0);

        // Start on the first edge after release.
        do_start(16'd5, 16'd5);
        wait_done(32'h00000019, 5, "mul_5x5");
        repeat (3) @(negedge Clock);
        check("hold_25", oOUT, 32'd25);

        @(negedge Clock);
        do_start(16'hFFFF, 16'hFFFF);
        wait_done(32'hFFFE0001, 5, "mul_max");
        // Started in the oDone cycle.
        do_start(16'h1234, 16'h5678);
        wait_done(32'h06260060, 5, "mul_b2b");

        @(negedge Clock);
        do_start(16'h0000, 16'hBEEF);
        wait_done(32'h00000000, 5, "mul_zero");
        @(negedge Clock);
        do_start(16'h0001, 16'h8000);
        wait_done(32'h00008000, 5, "mul_msb");

        // Second request while busy, with changed operands, is ignored.
        @(negedge Clock);
        do_start(16'h0003, 16'h0007);
        @(negedge Clock);
        wA     = 16'h0009;
        wB     = 16'h0009;
        iStart = 1'b1;
        @(negedge Clock);
        iStart = 1'b0;
        wait_done(32'h00000015, 3, "mul_ignore");
        nd = 0;
        repeat (8) begin
            @(negedge Clock);
            if (oDone) nd++;
        end
        check("ignore_no_second_done", 32'(nd), 32'd0);
        check("ignore_out_hold", oOUT, 32'h00000015);

        // Reset two cycles into an operation aborts it.
        @(negedge Clock);
        do_start(16'h00FF, 16'h0100);
        @(posedge Clock);
        #2;
        @(posedge Clock);
        #2;
        Reset = 1'b0;
        #1;
        check("abort_out",  oOUT,       32'h0);
        check("abort_busy", 32'(oBusy), 32'd0);
        check("abort_done", 32'(oDone), 32'd0);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        nd = 0;
        repeat (8) begin
            @(negedge Clock);
            if (oDone) nd++;
        end
        check("abort_no_done", 32'(nd), 32'd0);
        @(negedge Clock);
        do_start(16'h00FF, 16'h0100);
        wait_done(32'h0000FF00, 5, "mul_rerun");

        repeat (2) @(negedge Clock);
        chk_en = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
